// File: rtl/dcache_resp.sv
// Data-cache responder for the execute-stage request bus: direct-mapped, one word per line,
// write-through / no-write-allocate, with a req/ack memory port and dcache CACOP invalidates.
module dcache_resp #(
  parameter int SETS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [106:0] req_bus,
  output logic [35:0]  resp_bus,
  input  logic         icache_cacop_rdy,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [3:0]   mem_wstrb,
  output logic [31:0]  mem_wdata,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, RESP, WRITE, CACOP} state_t;

  logic             in_valid, in_op, in_unc, dc_en, ic_en;
  logic [31:0]      in_addr, in_wdata, in_cop_addr;
  logic [3:0]       in_strb;
  logic [1:0]       in_code;

  assign {in_valid, in_op, in_addr, in_unc, in_strb, in_wdata,
          dc_en, ic_en, in_code, in_cop_addr} = req_bus;

  state_t           state_q, state_d;
  logic             op_q, op_d, unc_q, unc_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, cop_addr_q, cop_addr_d;
  logic [3:0]       strb_q, strb_d;
  logic [1:0]       cop_code_q, cop_code_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [SETS-1:0]  valid_q, valid_d;

  logic [TAG_W-1:0] tag_mem [SETS];
  logic [31:0]      data_mem [SETS];
  logic [TAG_W-1:0] tag_rd_q;
  logic [31:0]      data_rd_q;

  logic             ready, rvalid, dcop_rdy, arr_we, hit;
  logic [31:0]      rdata, arr_data, merged;
  logic [IDX_W-1:0] rd_idx, q_idx, c_idx, in_idx, cin_idx;
  logic [TAG_W-1:0] q_tag, c_tag;

  assign q_idx   = addr_q[IDX_W+1:2];
  assign q_tag   = addr_q[31:IDX_W+2];
  assign c_idx   = cop_addr_q[IDX_W+1:2];
  assign c_tag   = cop_addr_q[31:IDX_W+2];
  assign in_idx  = in_addr[IDX_W+1:2];
  assign cin_idx = in_cop_addr[IDX_W+1:2];

  // The array is read one cycle ahead (at accept / cacop entry), so tag_rd_q and
  // data_rd_q belong to the registered request in the following state.
  assign hit = valid_q[q_idx] && (tag_rd_q == q_tag);

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged[8*gi +: 8] = strb_q[gi] ? wdata_q[8*gi +: 8] : data_rd_q[8*gi +: 8];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    unc_d      = unc_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    cop_code_d = cop_code_q;
    cop_addr_d = cop_addr_q;
    rdata_d    = rdata_q;
    valid_d    = valid_q;
    ready      = 1'b0;
    rvalid     = 1'b0;
    rdata      = '0;
    dcop_rdy   = 1'b0;
    mem_req    = 1'b0;
    arr_we     = 1'b0;
    arr_data   = mem_rdata;
    rd_idx     = q_idx;
    case (state_q)
      IDLE: begin
        ready  = ~dc_en;
        rd_idx = dc_en ? cin_idx : in_idx;
        if (dc_en) begin
          state_d    = CACOP;
          cop_code_d = in_code;
          cop_addr_d = in_cop_addr;
        end else if (in_valid) begin
          op_d    = in_op;
          addr_d  = in_addr;
          unc_d   = in_unc;
          strb_d  = in_strb;
          wdata_d = in_wdata;
          state_d = in_op ? WRITE : (in_unc ? MISS : LOOKUP);
        end
      end
      LOOKUP: begin
        if (hit) begin
          rvalid  = 1'b1;
          rdata   = data_rd_q;
          state_d = IDLE;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = RESP;
          if (!unc_q) begin
            arr_we         = 1'b1;
            valid_d[q_idx] = 1'b1;
          end
        end
      end
      RESP: begin
        rvalid  = 1'b1;
        rdata   = rdata_q;
        state_d = IDLE;
      end
      WRITE: begin
        mem_req = 1'b1;
        // Re-merging on later WRITE cycles rewrites the same word, so no first-cycle flag is needed.
        if (!unc_q && hit) begin
          arr_we   = 1'b1;
          arr_data = merged;
        end
        if (mem_ack) state_d = IDLE;
      end
      CACOP: begin
        dcop_rdy = 1'b1;
        case (cop_code_q)
          2'd0, 2'd1: valid_d[c_idx] = 1'b0;
          2'd2:       if (tag_rd_q == c_tag) valid_d[c_idx] = 1'b0;
          default:    ;
        endcase
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      ready    = 1'b0;
      rvalid   = 1'b0;
      rdata    = '0;
      dcop_rdy = 1'b0;
      mem_req  = 1'b0;
      arr_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q       <= op_d;
    addr_q     <= addr_d;
    unc_q      <= unc_d;
    strb_q     <= strb_d;
    wdata_q    <= wdata_d;
    cop_code_q <= cop_code_d;
    cop_addr_q <= cop_addr_d;
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_mem[q_idx]  <= q_tag;
      data_mem[q_idx] <= arr_data;
    end
    tag_rd_q  <= tag_mem[rd_idx];
    data_rd_q <= data_mem[rd_idx];
  end

  assign mem_we    = op_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wstrb = strb_q;
  assign mem_wdata = wdata_q;

  assign resp_bus = {ready, rvalid, rdata, icache_cacop_rdy, dcop_rdy};

  logic unused;
  assign unused = ^{ic_en, addr_q[1:0], cop_addr_q[1:0]};
endmodule

// File: tb/tb_dcache_resp.sv
// Scoreboard bench for dcache_resp: stimulus queues expected read data and memory requests,
// a monitor checks responses and a memory model checks/answers the memory port.
module tb_dcache_resp;
  logic         clk = 1'b0;
  logic         reset;
  logic [106:0] req_bus;
  logic [35:0]  resp_bus;
  logic         icache_cacop_rdy;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_wstrb;

  logic        r_valid, r_op, r_unc, dc_en, ic_en;
  logic [31:0] r_addr, r_wdata, c_addr;
  logic [3:0]  r_strb;
  logic [1:0]  c_code;

  assign req_bus = {r_valid, r_op, r_addr, r_unc, r_strb, r_wdata, dc_en, ic_en, c_code, c_addr};

  wire        ready  = resp_bus[35];
  wire        rvalid = resp_bus[34];
  wire [31:0] rdata  = resp_bus[33:2];
  wire        icr    = resp_bus[1];
  wire        dcr    = resp_bus[0];

  dcache_resp dut (
    .clk(clk), .reset(reset), .req_bus(req_bus), .resp_bus(resp_bus),
    .icache_cacop_rdy(icache_cacop_rdy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic ack_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ack_seen <= mem_ack;
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string msg);
    checks++;
    $display("FAIL %s", msg);
  endtask

  typedef struct { logic [31:0] data; int acc; bit hit; } rd_exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata;
                   logic [31:0] rdata; int delay; } mem_exp_t;
  rd_exp_t  rd_q[$];
  mem_exp_t mq[$];

  // Response monitor
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rvalid) begin
        chk("rvalid_with_ready", ready, 0);
        if (rd_q.size() == 0) begin
          fail($sformatf("unexpected_rvalid data %h", rdata));
        end else begin
          e = rd_q.pop_front();
          chk("rdata", rdata, e.data);
          $display("read resp data=%h exp=%h hit=%0d", rdata, e.data, e.hit);
          if (e.hit) chk("hit_latency", cyc - e.acc, 1);
          else       chk("rvalid_after_ack", ack_seen, 1);
        end
      end else begin
        chk("rdata_zero_when_idle", rdata, 0);
      end
    end
  end

  // Memory model
  initial begin
    mem_exp_t m;
    bit aborted, stable;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (mq.size() == 0) begin
          fail($sformatf("unexpected_mem_req addr %h we %0d", mem_addr, mem_we));
          mem_ack = 1'b1;
          @(negedge clk);
          mem_ack = 1'b0;
        end else begin
          m = mq.pop_front();
          $display("mem req we=%0d addr=%h strb=%b wdata=%h delay=%0d",
                   mem_we, mem_addr, mem_wstrb, mem_wdata, m.delay);
          chk("mem_we", mem_we, m.we);
          chk("mem_addr", mem_addr, m.addr);
          if (m.we) begin
            chk("mem_wstrb", mem_wstrb, m.strb);
            chk("mem_wdata", mem_wdata, m.wdata);
          end
          aborted = 1'b0;
          stable  = 1'b1;
          for (int i = 0; i < m.delay; i++) begin
            @(negedge clk);
            #1;
            if (!mem_req) begin
              aborted = 1'b1;
              break;
            end
            if (mem_addr !== m.addr || mem_wdata !== m.wdata && m.we) stable = 1'b0;
          end
          chk("mem_fields_stable", stable, 1);
          if (!aborted) begin
            mem_ack   = 1'b1;
            mem_rdata = m.rdata;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = '0;
            #1;
            chk("mem_req_after_ack", mem_req, 0);
          end
        end
      end
    end
  end

  task automatic wait_accept(output int acc);
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      fail("accept_timeout");
      r_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      r_valid = 1'b0;
    end
  endtask

  task automatic set_req(input logic op, input logic [31:0] addr, input logic unc,
                         input logic [3:0] strb, input logic [31:0] wd);
    r_op = op; r_addr = addr; r_unc = unc; r_strb = strb; r_wdata = wd;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic unc, input logic [31:0] exp,
                         input bit hit, input int delay);
    int acc;
    if (!hit) mq.push_back('{1'b0, {addr[31:2], 2'b00}, 4'h0, 32'h0, exp, delay});
    @(negedge clk);
    set_req(1'b0, addr, unc, 4'h0, 32'h0);
    r_valid = 1'b1;
    wait_accept(acc);
    rd_q.push_back('{exp, acc, hit});
  endtask

  task automatic do_write(input logic [31:0] addr, input logic unc, input logic [3:0] strb,
                          input logic [31:0] wd, input int delay);
    int acc;
    mq.push_back('{1'b1, {addr[31:2], 2'b00}, strb, wd, 32'h0, delay});
    @(negedge clk);
    set_req(1'b1, addr, unc, strb, wd);
    r_valid = 1'b1;
    wait_accept(acc);
  endtask

  task automatic do_cacop(input logic [1:0] code, input logic [31:0] addr, input bit with_read);
    bit got = 1'b0;
    @(negedge clk);
    dc_en = 1'b1; c_code = code; c_addr = addr;
    if (with_read) r_valid = 1'b1;
    #1;
    if (with_read) chk("ready_low_with_cacop", ready, 0);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) #1;
      if (dcr) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      fail("cacop_ready_timeout");
      dc_en = 1'b0;
    end else begin
      $display("cacop code=%0d addr=%h ready seen", code, addr);
      dc_en = 1'b0;
      @(negedge clk);
      #1;
      chk("cacop_ready_pulse", dcr, 0);
    end
  endtask

  initial begin
    int acc;
    bit seen;
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit seen;
    reset = 1'b1; icache_cacop_rdy = 1'b0;
    r_valid = 1'b0; r_op = 1'b0; r_unc = 1'b0; dc_en = 1'b0; ic_en = 1'b0;
    r_addr = '0; r_wdata = '0; c_addr = '0; r_strb = '0; c_code = '0;

    // 1: reset with a read already presented, then miss and hit
    set_req(1'b0, 32'h1C00_0040, 1'b0, 4'h0, 32'h0);
    r_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("reset_ready", ready, 0);
      chk("reset_resp_bus", resp_bus, 0);
      chk("reset_mem_req", mem_req, 0);
    end
    mq.push_back('{1'b0, 32'h1C00_0040, 4'h0, 32'h0, 32'h1122_3344, 2});
    @(negedge clk);
    reset = 1'b0;
    wait_accept(acc);
    rd_q.push_back('{32'h1122_3344, acc, 1'b0});
    do_read(32'h1C00_0040, 1'b0, 32'h1122_3344, 1'b1, 0);

    // 2: partial write hit merges into the line
    do_write(32'h1C00_0040, 1'b0, 4'b0010, 32'h0000_AB00, 1);
    do_read(32'h1C00_0040, 1'b0, 32'h1122_AB44, 1'b1, 0);

    // 3: write miss does not allocate
    do_write(32'h1C00_0080, 1'b0, 4'hF, 32'hDEAD_BEEF, 0);
    do_read(32'h1C00_0080, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);
    do_read(32'h1C00_0080, 1'b0, 32'hDEAD_BEEF, 1'b1, 0);

    // 4: uncached accesses bypass the array
    do_read(32'hBFAF_0000, 1'b1, 32'hCAFE_0001, 1'b0, $urandom_range(0, 5));
    do_read(32'hBFAF_0000, 1'b1, 32'hCAFE_0002, 1'b0, $urandom_range(0, 5));
    do_read(32'h1C00_0040, 1'b1, 32'h9999_9999, 1'b0, $urandom_range(0, 5));
    do_write(32'h1C00_0040, 1'b1, 4'hF, 32'h1234_5678, $urandom_range(0, 5));
    do_read(32'h1C00_0040, 1'b0, 32'h1122_AB44, 1'b1, 0);

    // 5: cacop hit invalidate, tag mismatch, no-op, and priority over a read
    do_cacop(2'd2, 32'h1C00_0040, 1'b0);
    do_read(32'h1C00_0040, 1'b0, 32'h5A5A_5A5A, 1'b0, 1);
    do_cacop(2'd2, 32'h1C00_1040, 1'b0);
    do_read(32'h1C00_0040, 1'b0, 32'h5A5A_5A5A, 1'b1, 0);
    do_cacop(2'd3, 32'h1C00_0040, 1'b0);
    do_read(32'h1C00_0040, 1'b0, 32'h5A5A_5A5A, 1'b1, 0);
    set_req(1'b0, 32'h1C00_0040, 1'b0, 4'h0, 32'h0);
    mq.push_back('{1'b0, 32'h1C00_0040, 4'h0, 32'h0, 32'h5566_7788, 0});
    do_cacop(2'd0, 32'h1C00_0040, 1'b1);
    wait_accept(acc);
    rd_q.push_back('{32'h5566_7788, acc, 1'b0});

    // icache ready relay
    @(negedge clk);
    icache_cacop_rdy = 1'b1; ic_en = 1'b1;
    #1;
    chk("icache_ready_relay_1", icr, 1);
    icache_cacop_rdy = 1'b0;
    #1;
    chk("icache_ready_relay_0", icr, 0);
    ic_en = 1'b0;

    // 6: reset in the middle of a miss
    mq.push_back('{1'b0, 32'h1C00_0100, 4'h0, 32'h0, 32'hBAD0_BAD0, 5});
    @(negedge clk);
    set_req(1'b0, 32'h1C00_0100, 1'b0, 4'h0, 32'h0);
    r_valid = 1'b1;
    wait_accept(acc);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("miss_mem_req_seen", seen, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_reset_mem_req", mem_req, 0);
    chk("mid_reset_ready", ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_after_reset", ready, 1);
    do_read(32'h1C00_0040, 1'b0, 32'h7777_7777, 1'b0, 2);

    repeat (10) @(negedge clk);
    chk("read_queue_drained", rd_q.size(), 0);
    chk("mem_queue_drained", mq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
